snake_game_ctrl: RTL



---
 rtl/snake_pkg.sv | 19 +
 rtl/snake_game_ctrl_if.sv | 9 +
 rtl/snake_move_timer.sv | 60 ++++++
 rtl/snake_game_ctrl.sv | 123 ++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared snake game types and default timing constants, used by the
// controller and by the VGA/movement blocks.
package snake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PLAY     = 2'd1,
    ST_RELOCATE = 2'd2,
    ST_END      = 2'd3
  } state_t;

  localparam int SCORE_W       = 4;
  localparam int SCORE_WIN_DEF = 15;
  localparam int TICK_BASE_DEF = 25000000;
  localparam int TICK_STEP_DEF = 1500000;
  localparam int TICK_MIN_DEF  = 2500000;
  localparam int TICK_W_DEF    = 25;

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Target placement request/acknowledge handshake between the game
// controller (master) and the target placer (slave).
interface snake_game_ctrl_if;
  logic TARGET_REQ;
  logic TARGET_ACK;

  modport master (output TARGET_REQ, input TARGET_ACK);
  modport slave  (input TARGET_REQ, output TARGET_ACK);
endinterface

// File: rtl/snake_move_timer.sv
// Snake move tick generator; the move period shrinks with the score and
// is floored at TICK_MIN.
module snake_move_timer
  import snake_pkg::*;
#(
  parameter int SCORE_W   = snake_pkg::SCORE_W,
  parameter int TICK_BASE = TICK_BASE_DEF,
  parameter int TICK_STEP = TICK_STEP_DEF,
  parameter int TICK_MIN  = TICK_MIN_DEF,
  parameter int TICK_W    = TICK_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [SCORE_W-1:0] score,
  output logic               MOVE_TICK
);

  localparam int PW = TICK_W + SCORE_W;
  localparam logic [PW-1:0] BASE_W = PW'(TICK_BASE);
  localparam logic [PW-1:0] STEP_W = PW'(TICK_STEP);
  localparam logic [PW-1:0] MIN_W  = PW'(TICK_MIN);

  logic [PW-1:0]     prod;
  logic [TICK_W-1:0] period_next;
  logic [TICK_W-1:0] period_q;
  logic [TICK_W-1:0] cnt_q;

  // Subtraction is guarded so a large score saturates at the floor
  // instead of wrapping negative.
  always_comb begin
    prod = PW'(score) * STEP_W;
    if (prod >= BASE_W || (BASE_W - prod) < MIN_W)
      period_next = TICK_W'(TICK_MIN);
    else
      period_next = TICK_W'(BASE_W - prod);
  end

  // The period is reloaded only at a wrap, so a score change never
  // truncates the move already in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      period_q  <= TICK_W'(TICK_BASE);
      MOVE_TICK <= 1'b0;
    end else if (!enable) begin
      cnt_q     <= '0;
      period_q  <= TICK_W'(TICK_BASE);
      MOVE_TICK <= 1'b0;
    end else if (cnt_q == period_q - 1'b1) begin
      cnt_q     <= '0;
      period_q  <= period_next;
      MOVE_TICK <= 1'b1;
    end else begin
      cnt_q     <= cnt_q + 1'b1;
      MOVE_TICK <= 1'b0;
    end
  end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: score keeping, target relocation handshake,
// move tick generation and game-over/win detection.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int SCORE_W   = snake_pkg::SCORE_W,
  parameter int SCORE_WIN = SCORE_WIN_DEF,
  parameter int TICK_BASE = TICK_BASE_DEF,
  parameter int TICK_STEP = TICK_STEP_DEF,
  parameter int TICK_MIN  = TICK_MIN_DEF,
  parameter int TICK_W    = TICK_W_DEF
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     START,
  input  logic                     REACHED_TARGET,
  input  logic                     COLLISION,
  snake_game_ctrl_if.master        tgt,
  output logic                     MOVE_TICK,
  output logic [SCORE_W-1:0]       CURRENT_SCORE,
  output logic [1:0]               STATE,
  output logic                     WIN,
  output logic                     GAME_OVER
);

  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(SCORE_WIN);

  state_t             state_q;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_inc;
  logic               req_q;
  logic               req_new_q;
  logic               win_q;
  logic               go_q;
  logic [2:0]         sync_q;
  logic               hit_p;
  logic               run;
  logic               tick_raw;

  // Two synchroniser stages plus one history flop for the rising edge.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) sync_q <= '0;
    else          sync_q <= {sync_q[1:0], REACHED_TARGET};
  end

  assign hit_p     = sync_q[1] & ~sync_q[2];
  assign score_inc = score_q + 1'b1;
  assign run       = (state_q == ST_PLAY) || (state_q == ST_RELOCATE);

  // req_new_q masks an ACK in the first RELOCATE cycle so REQ is seen.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      score_q   <= '0;
      req_q     <= 1'b0;
      req_new_q <= 1'b0;
      win_q     <= 1'b0;
      go_q      <= 1'b0;
    end else begin
      req_new_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_END: begin
          if (START) begin
            state_q <= ST_PLAY;
            score_q <= '0;
            win_q   <= 1'b0;
            go_q    <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (COLLISION) begin
            state_q <= ST_END;
            go_q    <= 1'b1;
          end else if (hit_p) begin
            score_q <= score_inc;
            if (score_inc == WIN_VAL) begin
              state_q <= ST_END;
              win_q   <= 1'b1;
            end else begin
              state_q   <= ST_RELOCATE;
              req_q     <= 1'b1;
              req_new_q <= 1'b1;
            end
          end
        end
        ST_RELOCATE: begin
          if (COLLISION) begin
            state_q <= ST_END;
            go_q    <= 1'b1;
            req_q   <= 1'b0;
          end else if (tgt.TARGET_ACK && !req_new_q) begin
            state_q <= ST_PLAY;
            req_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  snake_move_timer #(
    .SCORE_W  (SCORE_W),
    .TICK_BASE(TICK_BASE),
    .TICK_STEP(TICK_STEP),
    .TICK_MIN (TICK_MIN),
    .TICK_W   (TICK_W)
  ) u_timer (
    .clk      (CLK),
    .rst_n    (RESET_N),
    .enable   (run),
    .score    (score_q),
    .MOVE_TICK(tick_raw)
  );

  // A tick registered on the edge that ends the game must not leak into END.
  assign MOVE_TICK      = tick_raw & run;
  assign tgt.TARGET_REQ = req_q;
  assign CURRENT_SCORE  = score_q;
  assign STATE          = state_q;
  assign WIN            = win_q;
  assign GAME_OVER      = go_q;

endmodule
